// File: rtl/port_requester.sv
// rtl/port_requester.sv - per-frame output-port requester: requests, waits for grant, forwards or drops
//
// Ports:
//   clk_i, rst_ni              clock and asynchronous active-low reset
//   in_valid_i/in_data_i/in_last_i/in_dest_i/in_ready_o
//                              incoming frame beats; dest sampled on the first beat
//   request_o, grant_i         one-hot request to the output-port arbiter and its grant vector
//   out_valid_o/out_data_o/out_last_o
//                              forwarded beats towards the crossbar
//   frame_cnt_o, drop_cnt_o    wrapping counts of forwarded and dropped frames
module port_requester #(
    parameter int NUM_PORTS  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255,
    localparam int DEST_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_last_i,
    input  logic [DEST_W-1:0]     in_dest_i,
    output logic                  in_ready_o,
    output logic [NUM_PORTS-1:0]  request_o,
    input  logic [NUM_PORTS-1:0]  grant_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic [15:0]           frame_cnt_o,
    output logic [15:0]           drop_cnt_o
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [DEST_W:0]   PORT_LIMIT = (DEST_W + 1)'(NUM_PORTS);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        TRANSFER,
        DROP,
        RELEASE
    } state_t;

    state_t               state_q, state_d;
    logic [DEST_W-1:0]    dest_q, dest_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [NUM_PORTS-1:0] request_d;
    logic                 grant_sel;
    logic                 frame_inc, drop_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            wait_q      <= '0;
            request_o   <= '0;
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            wait_q    <= wait_d;
            request_o <= request_d;
            if (frame_inc) frame_cnt_o <= frame_cnt_o + 16'd1;
            if (drop_inc)  drop_cnt_o  <= drop_cnt_o + 16'd1;
        end
    end

    always_comb begin
        // Only the granted bit for our own destination matters.
        grant_sel = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (dest_q == DEST_W'(i)) grant_sel = grant_i[i];
        end

        state_d     = state_q;
        dest_d      = dest_q;
        wait_d      = wait_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        out_data_o  = '0;
        frame_inc   = 1'b0;
        drop_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                // The first beat is left in place; it is consumed in TRANSFER or DROP.
                if (in_valid_i) begin
                    dest_d = in_dest_i;
                    if ({1'b0, in_dest_i} < PORT_LIMIT) begin
                        state_d = REQUEST;
                        wait_d  = '0;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            REQUEST: begin
                wait_d = wait_q + 1'b1;
                // Grant is checked first so a grant in the timeout cycle still wins.
                if (grant_sel)                state_d = TRANSFER;
                else if (wait_q == WAIT_LAST) state_d = DROP;
            end
            TRANSFER: begin
                in_ready_o  = grant_sel;
                out_valid_o = in_valid_i & grant_sel;
                out_last_o  = out_valid_o & in_last_i;
                out_data_o  = out_valid_o ? in_data_i : '0;
                if (out_valid_o && in_last_i) begin
                    state_d   = RELEASE;
                    frame_inc = 1'b1;
                end
            end
            DROP: begin
                in_ready_o = 1'b1;
                if (in_valid_i && in_last_i) begin
                    state_d  = RELEASE;
                    drop_inc = 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // request_o is registered from the next state so it is one-hot exactly
        // while in REQUEST/TRANSFER and appears one cycle after the frame start.
        request_d = '0;
        if (state_d == REQUEST || state_d == TRANSFER) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                request_d[i] = (dest_d == DEST_W'(i));
            end
        end
    end

endmodule
